// File: rtl/rvfi_commit_checker.sv
// rvfi_commit_checker: N-lane RVFI commit-stream checker/profiler (packing, order, halt, segments).
// Optional idle watchdog is built when RVFI_CHK_WATCHDOG_EN is defined.
module rvfi_commit_checker #(
  parameter int NUM_CH  = 8,
  parameter int ORDER_W = 64,
  parameter int CNT_W   = 48,
  parameter int TIMEOUT = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         valid,
  input  logic [NUM_CH*ORDER_W-1:0] order,
  input  logic [NUM_CH*32-1:0]      inst,
  input  logic [NUM_CH*32-1:0]      pc_rdata,
  input  logic [NUM_CH*32-1:0]      pc_wdata,
  output logic                      halt,
  output logic                      error,
  output logic [3:0]                err_code,
  output logic [ORDER_W-1:0]        err_order,
  output logic [CNT_W-1:0]          inst_count,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      seg_active,
  output logic [CNT_W-1:0]          seg_inst_count,
  output logic [CNT_W-1:0]          seg_cycle_count
);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam logic [31:0] START_MARK = 32'h0010_2013;
  localparam logic [31:0] STOP_MARK  = 32'h0020_2013;

  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT < 2) begin : g_param_check
    $error("rvfi_commit_checker: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, SEG, DONE} state_t;

  state_t             state_reg, state_next;
  logic [ORDER_W-1:0] exp_order_reg;
  logic               halt_reg, error_reg;
  logic [3:0]         err_code_reg, err_new;
  logic [ORDER_W-1:0] err_order_reg;
  logic [CNT_W-1:0]   inst_count_reg, cycle_count_reg;
  logic               seg_active_reg, seg_active_next;
  logic [CNT_W-1:0]   seg_inst_reg, seg_inst_next, seg_cycle_reg, seg_cycle_next;
  logic [CNT_W-1:0]   inst_sat, cycle_sat, seg_inst_sat, seg_cycle_sat;
  logic [CNT_W:0]     inst_sum, seg_inst_sum;
  logic [PW-1:0]      pop;
  logic [NUM_CH:0]    valid_ext;
  logic [NUM_CH-1:0]  ord_bad, halt_cand, start_hit, stop_hit;
  logic               hole, halt_found, after_halt, live, halt_hit;
  logic               any_valid, start_any, stop_any, wd_err;

  // Per-lane decode of order, halt candidates and segment markers.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [ORDER_W-1:0] lane_order;
    logic [31:0]        lane_inst;
    assign lane_order    = order[gi*ORDER_W +: ORDER_W];
    assign lane_inst     = inst[gi*32 +: 32];
    assign ord_bad[gi]   = valid[gi] && (lane_order != exp_order_reg + ORDER_W'(gi));
    assign halt_cand[gi] = valid[gi] && ((pc_rdata[gi*32 +: 32] == pc_wdata[gi*32 +: 32]) ||
                           (lane_inst == 32'h0000_0063) || (lane_inst == 32'h0000_006f) ||
                           (lane_inst == 32'hF000_2013));
    assign start_hit[gi] = valid[gi] && (lane_inst == START_MARK);
    assign stop_hit[gi]  = valid[gi] && (lane_inst == STOP_MARK);
  end

  // A thermometer mask plus one has no bits in common with the mask itself.
  assign valid_ext = {1'b0, valid};
  assign hole      = |(valid_ext & (valid_ext + (NUM_CH+1)'(1)));
  assign any_valid = |valid;
  assign start_any = |start_hit;
  assign stop_any  = |stop_hit;
  assign live      = (state_reg == RUN) || (state_reg == SEG);
  assign halt_hit  = live && halt_found;

  always_comb begin
    pop        = '0;
    halt_found = 1'b0;
    after_halt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + PW'(valid[i]);
      if (halt_found && valid[i]) after_halt = 1'b1;
      if (halt_cand[i]) halt_found = 1'b1;
    end
  end

`ifdef RVFI_CHK_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wdog_reg, wdog_next;

  always_comb begin
    wdog_next = wdog_reg;
    wd_err    = 1'b0;
    if (live) begin
      if (any_valid) wdog_next = '0;
      else if (wdog_reg == WD_W'(TIMEOUT - 1)) wd_err = 1'b1;
      else wdog_next = wdog_reg + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_reg <= '0;
    else        wdog_reg <= wdog_next;
  end
`else
  assign wd_err = 1'b0;
`endif

  always_comb begin
    err_new    = '0;
    err_new[0] = hole;
    err_new[1] = |ord_bad;
    err_new[2] = wd_err;
    err_new[3] = (halt_hit && after_halt) || ((state_reg == DONE) && any_valid);
  end

  assign inst_sum      = {1'b0, inst_count_reg} + (CNT_W+1)'(pop);
  assign inst_sat      = inst_sum[CNT_W] ? '1 : inst_sum[CNT_W-1:0];
  assign cycle_sat     = (&cycle_count_reg) ? cycle_count_reg : cycle_count_reg + CNT_W'(1);
  assign seg_inst_sum  = {1'b0, seg_inst_reg} + (CNT_W+1)'(pop);
  assign seg_inst_sat  = seg_inst_sum[CNT_W] ? '1 : seg_inst_sum[CNT_W-1:0];
  assign seg_cycle_sat = (&seg_cycle_reg) ? seg_cycle_reg : seg_cycle_reg + CNT_W'(1);

  // Halt beats markers; a cycle carrying both start and stop leaves an empty, closed segment.
  always_comb begin
    state_next      = state_reg;
    seg_active_next = seg_active_reg;
    seg_inst_next   = seg_inst_reg;
    seg_cycle_next  = seg_cycle_reg;
    case (state_reg)
      IDLE: if (any_valid) state_next = RUN;
      RUN: begin
        if (halt_found) begin
          state_next = DONE;
        end else if (start_any) begin
          seg_inst_next  = '0;
          seg_cycle_next = '0;
          if (stop_any) begin
            seg_active_next = 1'b0;
          end else begin
            seg_active_next = 1'b1;
            state_next      = SEG;
          end
        end
      end
      SEG: begin
        if (halt_found) begin
          seg_inst_next   = seg_inst_sat;
          seg_cycle_next  = seg_cycle_sat;
          seg_active_next = 1'b0;
          state_next      = DONE;
        end else if (start_any) begin
          seg_inst_next  = '0;
          seg_cycle_next = '0;
          if (stop_any) begin
            seg_active_next = 1'b0;
            state_next      = RUN;
          end
        end else if (stop_any) begin
          seg_inst_next   = seg_inst_sat;
          seg_cycle_next  = seg_cycle_sat;
          seg_active_next = 1'b0;
          state_next      = RUN;
        end else begin
          seg_inst_next  = seg_inst_sat;
          seg_cycle_next = seg_cycle_sat;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      exp_order_reg   <= '0;
      halt_reg        <= 1'b0;
      error_reg       <= 1'b0;
      err_code_reg    <= '0;
      err_order_reg   <= '0;
      inst_count_reg  <= '0;
      cycle_count_reg <= '0;
      seg_active_reg  <= 1'b0;
      seg_inst_reg    <= '0;
      seg_cycle_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      exp_order_reg   <= exp_order_reg + ORDER_W'(pop);
      halt_reg        <= halt_reg | halt_hit;
      error_reg       <= error_reg | (|err_new);
      err_code_reg    <= err_code_reg | err_new;
      if (!error_reg && (|err_new)) err_order_reg <= exp_order_reg;
      inst_count_reg  <= inst_sat;
      cycle_count_reg <= cycle_sat;
      seg_active_reg  <= seg_active_next;
      seg_inst_reg    <= seg_inst_next;
      seg_cycle_reg   <= seg_cycle_next;
    end
  end

  assign halt            = halt_reg;
  assign error           = error_reg;
  assign err_code        = err_code_reg;
  assign err_order       = err_order_reg;
  assign inst_count      = inst_count_reg;
  assign cycle_count     = cycle_count_reg;
  assign seg_active      = seg_active_reg;
  assign seg_inst_count  = seg_inst_reg;
  assign seg_cycle_count = seg_cycle_reg;
endmodule

// File: tb/tb_rvfi_commit_checker.sv
// tb_rvfi_commit_checker: directed and randomized commit streams checked every cycle
// against a behavioural model of the commit-stream rules.
module tb_rvfi_commit_checker;
  localparam int NC = 4, OW = 8, CW = 10, TO = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] START_I = 32'h0010_2013;
  localparam logic [31:0] STOP_I  = 32'h0020_2013;
`ifdef RVFI_CHK_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NC-1:0] valid = '0;
  logic [NC*OW-1:0] order = '0;
  logic [NC*32-1:0] inst = '0, pc_rdata = '0, pc_wdata = '0;
  logic halt, error, seg_active;
  logic [3:0] err_code;
  logic [OW-1:0] err_order;
  logic [CW-1:0] inst_count, cycle_count, seg_inst_count, seg_cycle_count;

  always #5 clk = ~clk;

  rvfi_commit_checker #(.NUM_CH(NC), .ORDER_W(OW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .halt(halt), .error(error),
    .err_code(err_code), .err_order(err_order), .inst_count(inst_count),
    .cycle_count(cycle_count), .seg_active(seg_active),
    .seg_inst_count(seg_inst_count), .seg_cycle_count(seg_cycle_count));

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain integers describing what the outputs must be.
  int m_exp = 0, m_inst = 0, m_cyc = 0, m_err_order = 0, m_seg_inst = 0, m_seg_cyc = 0, m_wd = 0;
  bit m_started = 0, m_halted = 0, m_in_seg = 0;
  logic [3:0] m_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = 0; m_inst = 0; m_cyc = 0; m_err_order = 0; m_seg_inst = 0; m_seg_cyc = 0; m_wd = 0;
    m_started = 0; m_halted = 0; m_in_seg = 0; m_err = '0;
  endtask

  function automatic bit lane_is_halt(int i);
    logic [31:0] w;
    w = inst[i*32 +: 32];
    return valid[i] && ((pc_rdata[i*32 +: 32] == pc_wdata[i*32 +: 32]) ||
           w == 32'h0000_0063 || w == 32'h0000_006f || w == 32'hF000_2013);
  endfunction

  task automatic seg_count(input int k);
    m_seg_cyc  = (m_seg_cyc + 1 > CMAX) ? CMAX : m_seg_cyc + 1;
    m_seg_inst = (m_seg_inst + k > CMAX) ? CMAX : m_seg_inst + k;
  endtask

  // Applies the rules to the inputs sampled at this edge.
  task automatic model_update();
    int k, h;
    bit hole, bad_ord, start, stop, live, above;
    logic [3:0] new_err;
    if (!rst_n) begin model_reset(); return; end
    k = 0; h = -1; bad_ord = 0; start = 0; stop = 0; above = 0;
    for (int i = 0; i < NC; i++) begin
      if (valid[i]) begin
        k++;
        if (int'(order[i*OW +: OW]) != (m_exp + i) % 256) bad_ord = 1;
        if (inst[i*32 +: 32] == START_I) start = 1;
        if (inst[i*32 +: 32] == STOP_I) stop = 1;
        if (h < 0 && lane_is_halt(i)) h = i;
      end
    end
    if (h >= 0) for (int j = h + 1; j < NC; j++) if (valid[j]) above = 1;
    hole = (valid != NC'((1 << k) - 1));
    live = m_started && !m_halted;
    new_err = '0;
    new_err[0] = hole;
    new_err[1] = bad_ord;
    new_err[3] = (live && h >= 0 && above) || (m_halted && k > 0);
`ifdef RVFI_CHK_WATCHDOG_EN
    if (live) begin
      if (k > 0) m_wd = 0;
      else if (m_wd == TO - 1) new_err[2] = 1'b1;
      else m_wd++;
    end
`endif
    if (m_err == 0 && new_err != 0) m_err_order = m_exp;
    m_err = m_err | new_err;
    if (!m_started) begin
      if (k > 0) m_started = 1;
    end else if (!m_halted) begin
      if (h >= 0) begin
        if (m_in_seg) seg_count(k);
        m_in_seg = 0; m_halted = 1;
      end else if (start) begin
        m_seg_cyc = 0; m_seg_inst = 0; m_in_seg = !stop;
      end else if (stop && m_in_seg) begin
        seg_count(k); m_in_seg = 0;
      end else if (m_in_seg) begin
        seg_count(k);
      end
    end
    m_cyc  = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
    m_inst = (m_inst + k > CMAX) ? CMAX : m_inst + k;
    m_exp  = (m_exp + k) % 256;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("halt", halt, m_halted);
      check("error", error, m_err != 0);
      check("err_code", err_code, m_err);
      check("err_order", err_order, m_err_order);
      check("inst_count", inst_count, m_inst);
      check("cycle_count", cycle_count, m_cyc);
      check("seg_active", seg_active, m_in_seg);
      check("seg_inst_count", seg_inst_count, m_seg_inst);
      check("seg_cycle_count", seg_cycle_count, m_seg_cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic set_plain(input logic [NC-1:0] v);
    logic [31:0] t;
    valid = v;
    for (int i = 0; i < NC; i++) begin
      t = $urandom();
      order[i*OW +: OW] = OW'(m_exp + i);
      inst[i*32 +: 32] = {t[31:7], 7'h33};
      t = $urandom() & 32'hFFFF_FFFC;
      pc_rdata[i*32 +: 32] = t;
      pc_wdata[i*32 +: 32] = t + 32'd4;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0; order = '0; inst = '0; pc_rdata = '0; pc_wdata = '0;
    #1;
    check("rst_halt", halt, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_err_order", err_order, 0);
    check("rst_inst_count", inst_count, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_seg_active", seg_active, 0);
    check("rst_seg_inst", seg_inst_count, 0);
    check("rst_seg_cycle", seg_cycle_count, 0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle(input int p_gap, input int p_halt);
    logic [NC-1:0] v;
    int k, s, ln;
    if ($urandom_range(0, 99) < p_gap) v = '0;
    else if ($urandom_range(0, 19) == 0) v = NC'($urandom_range(1, (1 << NC) - 1));
    else begin k = $urandom_range(1, NC); v = NC'((1 << k) - 1); end
    set_plain(v);
    ln = $urandom_range(0, NC - 1);
    if (v[ln]) begin
      s = $urandom_range(0, 99);
      if (s < 3) order[ln*OW +: OW] = order[ln*OW +: OW] ^ OW'(1 << $urandom_range(0, OW - 1));
      else if (m_started && s < 9) inst[ln*32 +: 32] = START_I;
      else if (m_started && s < 15) inst[ln*32 +: 32] = STOP_I;
      else if (m_started && s < 15 + p_halt) begin
        case ($urandom_range(0, 3))
          0: pc_wdata[ln*32 +: 32] = pc_rdata[ln*32 +: 32];
          1: inst[ln*32 +: 32] = 32'h0000_0063;
          2: inst[ln*32 +: 32] = 32'h0000_006f;
          default: inst[ln*32 +: 32] = 32'hF000_2013;
        endcase
      end
    end
    tick();
  endtask

  initial begin
    #1;
    chk_en = 1'b1;

    // Run A: packing, order contiguity and wrap, error capture, long random run.
    do_reset();
    set_plain(4'b0011); tick();
    set_plain(4'b1111); tick();
    check("t1_inst_count", inst_count, 6);
    check("t1_cycle_count", cycle_count, 2);
    check("t1_err_code", err_code, 0);
    for (int i = 0; i < 62; i++) begin set_plain(4'b1111); tick(); end
    set_plain(4'b1111); tick();                 // orders 254,255,0,1
    set_plain(4'b0001); tick();                 // order 2
    check("t3_wrap_err_code", err_code, 0);
    check("t3_inst_count", inst_count, 259);
    check("t3_cycle_count", cycle_count, 66);
    set_plain(4'b0101); tick();
    check("t2_hole_err_code", err_code, 4'b0001);
    check("t2_hole_error", error, 1);
    check("t2_err_order", err_order, 3);
    set_plain(4'b0011); order[OW +: OW] = OW'(m_exp + 3); tick();
    check("t3_order_err_code", err_code, 4'b0011);
    check("t3_err_order_kept", err_order, 3);
    for (int i = 0; i < 1000; i++) rand_cycle(10, 0);
    check("sat_cycle_count", cycle_count, CMAX);

    // Run B: segments, saturation, halt; the reset entering it checks immediate clear.
    do_reset();
    set_plain(4'b0001); tick();
    set_plain(4'b0001); inst[31:0] = START_I; tick();
    check("t4_seg_active_on", seg_active, 1);
    check("t4_seg_cycle_start", seg_cycle_count, 0);
    for (int i = 0; i < 10; i++) begin set_plain(4'b0011); tick(); end
    set_plain(4'b0011); inst[63:32] = STOP_I; tick();
    check("t4_seg_cycle", seg_cycle_count, 11);
    check("t4_seg_inst", seg_inst_count, 22);
    check("t4_seg_active_off", seg_active, 0);
    for (int i = 0; i < 3; i++) begin set_plain(4'b1111); tick(); end
    check("t4_seg_frozen", seg_inst_count, 22);
    set_plain(4'b0011); inst[31:0] = START_I; inst[63:32] = STOP_I; tick();
    check("startstop_seg_cycle", seg_cycle_count, 0);
    check("startstop_seg_active", seg_active, 0);
    set_plain(4'b0001); inst[31:0] = START_I; tick();
    for (int i = 0; i < 2; i++) begin set_plain(4'b0011); tick(); end
    check("restart_pre_inst", seg_inst_count, 4);
    set_plain(4'b0011); inst[63:32] = START_I; tick();
    check("restart_seg_cycle", seg_cycle_count, 0);
    check("restart_seg_active", seg_active, 1);
    for (int i = 0; i < 300; i++) begin set_plain(4'b1111); tick(); end
    check("sat_seg_inst", seg_inst_count, CMAX);
    check("sat_inst_count", inst_count, CMAX);
    check("b_cycle_count", cycle_count, 321);
    set_plain(4'b0111); inst[63:32] = 32'h0000_006f; tick();
    check("t5_halt", halt, 1);
    check("t5_err_code", err_code, 4'b1000);
    check("t5_seg_cycle", seg_cycle_count, 301);
    check("t5_seg_active", seg_active, 0);
    set_plain(4'b0001); tick();
    check("t5_done_err_code", err_code, 4'b1000);
    check("t5_done_seg_cycle", seg_cycle_count, 301);

    // Run C: idle watchdog boundary, then short random runs cut by resets.
    do_reset();
    set_plain(4'b0001); tick();
    for (int i = 0; i < 15; i++) begin set_plain(4'b0000); tick(); end
    check("t6_wdog_before", err_code[2], 0);
    set_plain(4'b0000); tick();
    check("t6_wdog_at", err_code[2], WD_EXP);
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) rand_cycle(15, 3);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
